// File: rtl/wallace_mac_pipe_pkg.sv
// Shared types, Booth codes and tree-shape helpers for wallace_mac_pipe.
// WALLACE_MAC_ACC_EN enables the dot-product accumulator stage.
package wallace_mac_pipe_pkg;

  localparam int WIDTH_DATA = 16;

`ifdef WALLACE_MAC_ACC_EN
  localparam int ACC_ON = 1;
`else
  localparam int ACC_ON = 0;
`endif

  typedef enum logic [2:0] {
    BOOTH_0,
    BOOTH_P1,
    BOOTH_P2,
    BOOTH_N1,
    BOOTH_N2
  } booth_t;

  function automatic booth_t booth_code(input logic [2:0] g);
    booth_t c;
    c = BOOTH_0;
    unique case (g)
      3'b001, 3'b010: c = BOOTH_P1;
      3'b011:         c = BOOTH_P2;
      3'b100:         c = BOOTH_N2;
      3'b101, 3'b110: c = BOOTH_N1;
      default:        c = BOOTH_0;
    endcase
    return c;
  endfunction

  // rows left after l levels of 3:2 compression
  function automatic int rows_after(input int n, input int l);
    int m;
    m = n;
    for (int k = 0; k < l; k++) m = m - m / 3;
    return m;
  endfunction

  function automatic int tree_levels(input int n);
    int m;
    int c;
    m = n;
    c = 0;
    while (m > 2) begin
      m = m - m / 3;
      c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/wallace_mac_pipe_csa.sv
// Bit-vector carry-save adder row: three rows in, sum and carry out.
// The carry is returned unshifted; the caller aligns it.
module csa_3_2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] cin,
  output logic [W-1:0] sum,
  output logic [W-1:0] cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/wallace_mac_pipe.sv
// Booth radix-4 / Wallace pipelined multiplier, optional accumulator.
// Define WALLACE_MAC_ACC_EN to add the dot-product accumulate stage.
module wallace_mac_pipe
  import wallace_mac_pipe_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DATA,
  parameter bit SIGNED    = 1'b1,
  parameter int ACC_GUARD = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_a,
  input  logic [WIDTH-1:0]                    in_b,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2*WIDTH+ACC_ON*ACC_GUARD-1:0] out_p
);

  localparam int PW  = 2 * WIDTH;
  localparam int F   = WIDTH + 2;
  localparam int NPP = WIDTH / 2 + (SIGNED ? 0 : 1);
  localparam int BE  = 2 * NPP + 1;
  localparam int R0  = NPP + 1;
  localparam int NLV = tree_levels(R0);

  logic          adv;
  logic [F-1:0]  am;
  logic [BE-1:0] b_ext;
  logic [F-1:0]  x;
  logic          neg;
  booth_t        code;
  logic [PW-1:0] comp;
  logic [PW-1:0] negs;
  logic [PW-1:0] pp [R0];

  logic          s1_v;
  logic [PW-1:0] s1_pp [R0];
  logic          s2_v;
  logic [PW-1:0] s2_sum;
  logic [PW-1:0] s2_car;
  logic [PW-1:0] lv [NLV+1][R0];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign am       = SIGNED ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
  assign b_ext    = BE'({in_b, 1'b0});

  // Booth rows with inverted-MSB sign handling; row NPP folds the
  // sign compensation constant together with the negate bits
  always_comb begin
    code = BOOTH_0;
    x    = '0;
    neg  = 1'b0;
    comp = '0;
    negs = '0;
    for (int i = 0; i < NPP; i++) begin
      code = booth_code(b_ext[2*i +: 3]);
      unique case (code)
        BOOTH_P1: x = am;
        BOOTH_P2: x = am << 1;
        BOOTH_N1: x = ~am;
        BOOTH_N2: x = ~(am << 1);
        default:  x = '0;
      endcase
      neg         = (code == BOOTH_N1) || (code == BOOTH_N2);
      negs[2*i]   = neg;
      pp[i]       = PW'({~x[F-1], x[F-2:0]}) << (2 * i);
      comp        = comp + (PW'(1) << (F - 1 + 2 * i));
    end
    pp[NPP] = (~comp + PW'(1)) | negs;
  end

  for (genvar r = 0; r < R0; r++) begin : g_l0
    assign lv[0][r] = s1_pp[r];
  end

  for (genvar l = 0; l < NLV; l++) begin : g_lvl
    localparam int N = rows_after(R0, l);
    localparam int G = N / 3;
    localparam int M = N - G;
    for (genvar g = 0; g < G; g++) begin : g_csa
      logic [PW-1:0] co;
      csa_3_2 #(.W(PW)) u_csa (
        .a   (lv[l][3*g]),
        .b   (lv[l][3*g+1]),
        .cin (lv[l][3*g+2]),
        .sum (lv[l+1][2*g]),
        .cout(co)
      );
      assign lv[l+1][2*g+1] = co << 1;
    end
    for (genvar r = 3 * G; r < N; r++) begin : g_pass
      assign lv[l+1][r-G] = lv[l][r];
    end
    for (genvar r = M; r < R0; r++) begin : g_zero
      assign lv[l+1][r] = '0;
    end
  end

`ifdef WALLACE_MAC_ACC_EN
  localparam int AW = PW + ACC_GUARD;
  logic          s1_last;
  logic          s2_last;
  logic          s3_v;
  logic          s3_last;
  logic [PW-1:0] s3_p;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;

  assign acc_nxt = acc + (SIGNED ? AW'($signed(s3_p)) : AW'(s3_p));
`else
  logic unused_last;
  assign unused_last = in_last;
`endif

  // S1: register partial-product rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_pp <= '{default: '0};
    end else if (adv) begin
      s1_v  <= in_valid;
      s1_pp <= pp;
    end
  end

  // S2: register the two rows left by the tree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_sum <= '0;
      s2_car <= '0;
    end else if (adv) begin
      s2_v   <= s1_v;
      s2_sum <= lv[NLV][0];
      s2_car <= lv[NLV][1];
    end
  end

`ifdef WALLACE_MAC_ACC_EN
  // last flag travels with its operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_last <= 1'b0;
      s2_last <= 1'b0;
    end else if (adv) begin
      s1_last <= in_last;
      s2_last <= s1_last;
    end
  end

  // S3: final carry-propagate add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v    <= 1'b0;
      s3_last <= 1'b0;
      s3_p    <= '0;
    end else if (adv) begin
      s3_v    <= s2_v;
      s3_last <= s2_last;
      s3_p    <= s2_sum + s2_car;
    end
  end

  // S4: accumulate; emit and restart from zero on the last term
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= s3_v && s3_last;
      if (s3_v) acc <= s3_last ? '0 : acc_nxt;
      if (s3_v && s3_last) out_p <= acc_nxt;
    end
  end
`else
  // S3: final carry-propagate add into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
    end else if (adv) begin
      out_valid <= s2_v;
      if (s2_v) out_p <= s2_sum + s2_car;
    end
  end
`endif

endmodule

// File: tb/tb_wallace_mac_pipe.sv
// Scoreboard bench for wallace_mac_pipe (WIDTH=16, SIGNED=1).
// Covers the accumulator build when WALLACE_MAC_ACC_EN is defined.
module tb_wallace_mac_pipe;
  import wallace_mac_pipe_pkg::*;

  localparam int OW = 32 + ACC_ON * 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_p;

  logic [OW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int extra = 0;

  wallace_mac_pipe #(
    .WIDTH(16),
    .SIGNED(1'b1),
    .ACC_GUARD(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p(out_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic last, input longint e,
                      input bit push, output int tries);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tries    = 0;
    for (int t = 0; t < 100; t++) begin
      tries++;
      #4;
      if (in_ready) begin
        if (push) exp_q.push_back(OW'(e));
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'(tries), 64'd0);
  endtask

  task automatic send_p(input logic [15:0] a, input logic [15:0] b);
    int tr;
    send(a, b, 1'b0,
         longint'($signed(a)) * longint'($signed(b)), 1'b1, tr);
    extra += tr - 1;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && exp_q.size() > 0; t++) @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic lat_chk(input int n);
    for (int k = 1; k <= n; k++) begin
      #1;
      chk($sformatf("lat_c%0d", k), 64'(out_valid), 64'(k == n));
      @(negedge clk);
    end
  endtask

  // monitor: pop and compare on every output handshake
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_p), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("product", 64'(out_p), 64'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tr;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

`ifdef WALLACE_MAC_ACC_EN
    send(16'd2, 16'd3, 1'b0, 0, 1'b0, tr);
    send(16'd4, -16'sd1, 1'b0, 0, 1'b0, tr);
    send(-16'sd7, 16'd2, 1'b1, -12, 1'b1, tr);
    lat_chk(4);
    drain();
    send(16'd5, 16'd5, 1'b0, 0, 1'b0, tr);
    send(16'd1, -16'sd1, 1'b1, 24, 1'b1, tr);
    send(16'd3, -16'sd5, 1'b1, -15, 1'b1, tr);
    send(-16'sd32768, -16'sd32768, 1'b0, 0, 1'b0, tr);
    send(-16'sd32768, -16'sd32768, 1'b1,
         longint'(64'h8000_0000), 1'b1, tr);
    drain();
    send(16'd9, 16'd9, 1'b0, 0, 1'b0, tr);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'd1, 16'd2, 1'b1, 2, 1'b1, tr);
    drain();
`else
    send(16'd3, -16'sd5, 1'b0, 32'shFFFF_FFF1, 1'b1, tr);
    lat_chk(3);
    drain();
    send(-16'sd32768, -16'sd32768, 1'b0, 32'sh4000_0000, 1'b1, tr);
    send(16'sd32767, -16'sd32768, 1'b0, 32'shC000_8000, 1'b1, tr);
    send(16'd0, 16'h1234, 1'b0, 0, 1'b1, tr);
    send(-16'sd1, -16'sd1, 1'b0, 1, 1'b1, tr);
    send(-16'sd1, 16'd1, 1'b0, 32'shFFFF_FFFF, 1'b1, tr);
    send(16'd255, 16'd255, 1'b0, 32'sh0000_FE01, 1'b1, tr);
    send(16'h7FFF, 16'h7FFF, 1'b0, 32'sh3FFF_0001, 1'b1, tr);
    extra = 0;
    for (int i = 0; i < 200; i++)
      send_p(16'($urandom), 16'($urandom));
    chk("throughput_stalls", 64'(extra), 64'd0);
    drain();

    fork
      begin
        for (int i = 0; i < 30; i++)
          send_p(16'($urandom), 16'($urandom));
      end
      begin
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #4;
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_out_p", 64'(out_p), 64'(exp_q[0]));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    send(16'd11, 16'd13, 1'b0, 143, 1'b1, tr);
    send(16'd17, -16'sd19, 1'b0, -323, 1'b1, tr);
    send(-16'sd23, -16'sd29, 1'b0, 667, 1'b1, tr);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_p", 64'(out_p), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #4;
      chk("post_rst_quiet", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    send(16'd7, 16'd6, 1'b0, 42, 1'b1, tr);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
